// File: rtl/arbiter_pkg.sv
// Shared types for the adder arbiter: state encoding and grant constants.
package arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_0    = 2'b01;
   localparam logic [1:0] GRANT_1    = 2'b10;

   function automatic logic [1:0] grant_of(state_e s);
      logic [1:0] g;
      g = GRANT_NONE;
      case (s)
         OWN0:    g = GRANT_0;
         OWN1:    g = GRANT_1;
         default: g = GRANT_NONE;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Client/adder bundle of the arbiter; slave = arbiter, master = clients + adder.
interface adder_arbiter_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       i_request;
   logic [1:0]       o_grant;
   logic             o_busy;
   logic [WIDTH-1:0] i_augend_0;
   logic [WIDTH-1:0] i_addend_0;
   logic [WIDTH-1:0] i_augend_1;
   logic [WIDTH-1:0] i_addend_1;
   logic [WIDTH-1:0] o_sum;
   logic             o_carry;
   logic [WIDTH-1:0] o_adder_augend;
   logic [WIDTH-1:0] o_adder_addend;
   logic [WIDTH-1:0] i_adder_sum;
   logic             i_adder_carry;

   modport slave (
      input  i_request,
      input  i_augend_0, i_addend_0,
      input  i_augend_1, i_addend_1,
      input  i_adder_sum, i_adder_carry,
      output o_grant, o_busy,
      output o_sum, o_carry,
      output o_adder_augend, o_adder_addend
   );

   modport master (
      output i_request,
      output i_augend_0, i_addend_0,
      output i_augend_1, i_addend_1,
      output i_adder_sum, i_adder_carry,
      input  o_grant, o_busy,
      input  o_sum, o_carry,
      input  o_adder_augend, o_adder_addend
   );
endinterface

// File: rtl/adder_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie the client not granted last wins.
module rr_pick (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       win_o,
   output logic       valid_o
);
   always_comb begin
      win_o   = 1'b0;
      valid_o = |req_i;
      case (req_i)
         2'b01:   win_o = 1'b0;
         2'b10:   win_o = 1'b1;
         2'b11:   win_o = ~last_i;
         default: win_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder between two iterative clients; grant is locked while
// the holder keeps requesting and hands off with no idle cycle.
module adder_arbiter
   import arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic            i_clock,
   input  logic            i_reset,
   adder_arbiter_if.slave  bus
);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_e state_q, state_d;
   logic   last_q, last_d;
   logic   pick_win, pick_valid;

   rr_pick u_pick (
      .req_i   (bus.i_request),
      .last_i  (last_q),
      .win_o   (pick_win),
      .valid_o (pick_valid)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = pick_win ? OWN1 : OWN0;
               last_d  = pick_win;
            end
         end
         OWN0: begin
            if (!bus.i_request[0]) begin
               if (bus.i_request[1]) begin
                  state_d = OWN1;
                  last_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         OWN1: begin
            if (!bus.i_request[1]) begin
               if (bus.i_request[0]) begin
                  state_d = OWN0;
                  last_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // last resets to 1 so client 0 takes the first tie
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      bus.o_adder_augend = ZERO;
      bus.o_adder_addend = ZERO;
      unique case (state_q)
         OWN0: begin
            bus.o_adder_augend = bus.i_augend_0;
            bus.o_adder_addend = bus.i_addend_0;
         end
         OWN1: begin
            bus.o_adder_augend = bus.i_augend_1;
            bus.o_adder_addend = bus.i_addend_1;
         end
         default: begin
            bus.o_adder_augend = ZERO;
            bus.o_adder_addend = ZERO;
         end
      endcase
   end

   assign bus.o_grant = grant_of(state_q);
   assign bus.o_busy  = |bus.o_grant;
   assign bus.o_sum   = bus.i_adder_sum;
   assign bus.o_carry = bus.i_adder_carry;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Sequential two-port arbiter that shares one `Adder` instance (width `2*N`) between two iterative datapath clients, e.g. `Multiplier` on port 0 and a future divider on port 1. Each client drives a request/grant handshake plus its augend/addend. The arbiter grants one client at a time, locks the grant while the request is held, and alternates round-robin on contention. It sits between the clients' `o_adder_*`/`i_adder_sum` ports and the shared `Adder`.

## Interface
- `WIDTH`, default 8: adder operand/sum width (`2*N` of the clients).
- `i_clock`, input, 1: sole clock, rising edge.
- `i_reset`, input, 1: asynchronous, active-low reset.
- `i_request`, input, 2: bit k set = client k wants the adder.
- `o_grant`, output, 2: one-hot or zero; bit k = client k owns the adder this cycle.
- `o_busy`, output, 1: `|o_grant`.
- `i_augend_0`, `i_addend_0`, input, `WIDTH`: client 0 operands.
- `i_augend_1`, `i_addend_1`, input, `WIDTH`: client 1 operands.
- `o_sum`, output, `WIDTH`: adder sum broadcast to both clients; meaningful only to the grant holder.
- `o_carry`, output, 1: adder carry broadcast.
- `o_adder_augend`, `o_adder_addend`, output, `WIDTH`: to shared `Adder`.
- `i_adder_sum`, input, `WIDTH`; `i_adder_carry`, input, 1: from shared `Adder`.

## Operation
- States:
  - `IDLE`: no grant.
  - `OWN0`: `o_grant=2'b01`.
  - `OWN1`: `o_grant=2'b10`.
- `o_grant` is decoded from the state register only (registered, glitch-free).
- Round-robin pointer `last`, 1 bit, holds the index of the most recently granted client.
  - Updated on every transition into `OWNk`.
  - Reset value 1, so client 0 wins the first tie.
- From `IDLE`:
  - Single request k goes to `OWNk`.
  - Both requesting goes to `OWN(~last)`.
  - No request stays in `IDLE`.
- From `OWNk`:
  - `i_request[k]=1` stays in `OWNk` (lock). There is no preemption and no hold limit.
  - `i_request[k]=0` with the other client requesting goes directly to the other client's `OWN` state (zero-bubble handoff).
  - `i_request[k]=0` with no other request goes to `IDLE`.
- Operand mux is combinational from the state:
  - `OWN0` drives client 0's operands.
  - `OWN1` drives client 1's operands.
  - `IDLE` drives all zeros.
- `o_sum`/`o_carry` pass `i_adder_sum`/`i_adder_carry` through unchanged; there is no truncation and no extension.
- A client must not use `o_sum` in a cycle where its grant bit is 0.

## Timing
- Reset (`i_reset=0`, asynchronous assert):
  - State `IDLE`, `last=1`.
  - `o_grant=0`, `o_busy=0`, `o_adder_augend=0`, `o_adder_addend=0`.
  - `o_sum`/`o_carry` follow the adder, which reads 0+0 = 0.
- Release is sampled at the first rising edge with `i_reset=1`.
- Grant latency is 1 cycle: request rising before edge t gives grant high after edge t, when the adder is free.
- Release latency is 1 cycle: the holder drops its request before edge t, and its grant is low after edge t.
- Handoff: the other client's grant rises at that same edge t, with no idle cycle.
- Operand-to-sum path is purely combinational through the arbiter (mux + adder). The client registers the result at the same edge it would without the arbiter.
- Simultaneous drop of holder and rise of the other client's request in the same cycle: handoff at that edge.
- Request withdrawn before being granted: no grant issued and `last` unchanged.
- Reset mid-grant: grant drops immediately (asynchronous) and operands go to 0. The client's own reset is expected to restart its operation.
- `i_request` is sampled synchronously only; there is no asynchronous path from request to grant.

## Structure
- Shared package `arbiter_pkg`:
  - state encoding `IDLE=2'd0`, `OWN0=2'd1`, `OWN1=2'd2`;
  - grant constants `GRANT_NONE`, `GRANT_0`, `GRANT_1`.
- One sub-module, `rr_pick`: combinational 2-way round-robin selector.
  - Inputs: request vector, `last`.
  - Outputs: winner index and valid.
- `adder_arbiter` holds the state register, `last`, and the operand mux.
- Testbench `AdderArbiterTB`:
  - one `Adder #(.N(WIDTH))`;
  - two `Multiplier #(.N(WIDTH/2))` clients, each request tied to its running status.

## Test plan
- Reset then idle:
  - Assert `i_reset=0` mid-run.
  - Required: `o_grant=0`, adder operands 0, `o_sum=0`.
  - After release with no requests, `o_grant` stays 0.
- Single client, N=4:
  - Only client 0 runs 13×11.
  - Required: `o_grant` becomes `2'b01` one cycle after request, product 143, `o_grant` back to 0 one cycle after request drops.
- Tie after reset:
  - Both request in the same cycle.
  - Required: client 0 granted first (7×9=63). On its release, client 1 is granted at that edge with no bubble (15×15=225).
- Round-robin:
  - Repeat the tie immediately after the previous test.
  - Required: client 0 granted again, since `last=1` after client 1 finished.
  - Then force `last=0` via a client 0 solo run followed by a tie; required: client 1 wins.
- Lock:
  - Client 1 requests while client 0 holds.
  - Required: `o_grant` stays `2'b01` for the whole operation, and client 1 receives no sum.
  - Both products correct (12×5=60, 3×14=42).
- Reset mid-grant:
  - Pulse `i_reset` low during client 0's third iteration.
  - Required: `o_grant=0` asynchronously, before the next edge.
  - After release and restart, 9×9=81.
